// File: rtl/div_arbiter_pkg.sv
// Shared types and sizing helpers for the round-robin divider arbiter.
// The sizing functions let the top derive widths for any LEN/NREQ.
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        RESP
    } state_t;

    localparam int LEN_DEF  = 16;
    localparam int NREQ_DEF = 4;

    function automatic int cnt_width(input int len);
        return $clog2(len) + 1;
    endfunction

    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    localparam int CNTW = cnt_width(LEN_DEF);
    localparam int IDW  = id_width(NREQ_DEF);

endpackage

// File: rtl/div_core.sv
// Radix-2 restoring divider datapath: one quotient bit per step pulse.
// Sequencing (step count, operand source) is owned by the instantiating block.
module div_core
    import div_arbiter_pkg::*;
#(
    parameter int LEN = LEN_DEF
) (
    input  logic           CLK,
    input  logic           load,
    input  logic           step,
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    output logic [LEN-1:0] nq,
    output logic [LEN-1:0] r,
    output logic           b_zero
);

    logic [LEN-1:0] d_q;
    logic [LEN-1:0] nq_q;
    logic [LEN-1:0] r_q;
    logic [LEN-1:0] nx_r;
    logic           fits;

    always_comb begin
        nx_r = {r_q[LEN-2:0], nq_q[LEN-1]};
        fits = (nx_r >= d_q);
    end

    // NOTE: datapath registers are not reset; a load always precedes any use of them.
    always_ff @(posedge CLK) begin
        if (load) begin
            d_q  <= b;
            nq_q <= a;
            r_q  <= '0;
        end else if (step) begin
            nq_q <= {nq_q[LEN-2:0], fits};
            r_q  <= fits ? (nx_r - d_q) : nx_r;
        end
    end

    assign nq     = nq_q;
    assign r      = r_q;
    assign b_zero = (d_q == '0);

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one sequential divider among NREQ requesters,
// returning ID-tagged quotient/remainder responses.
module div_arbiter
    import div_arbiter_pkg::*;
#(
    parameter int LEN  = LEN_DEF,
    parameter int NREQ = NREQ_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*LEN-1:0]       REQ_A,
    input  logic [NREQ*LEN-1:0]       REQ_B,
    output logic [NREQ-1:0]           ACK,
    output logic [NREQ-1:0]           RSP_VALID,
    output logic [id_width(NREQ)-1:0] RSP_ID,
    output logic [LEN-1:0]            Q,
    output logic [LEN-1:0]            R,
    output logic                      DIV0,
    output logic                      BUSY
);

    localparam int CW = cnt_width(LEN);
    localparam int IW = id_width(NREQ);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   gnt_id;
    logic [IW-1:0]   sel_id;
    logic [IW-1:0]   ptr_nxt;
    logic            found;
    logic            load;
    logic            step;
    logic            fin;
    logic [LEN-1:0]  sel_a;
    logic [LEN-1:0]  sel_b;
    logic [LEN-1:0]  core_nq;
    logic [LEN-1:0]  core_r;
    logic            core_bz;
    logic [LEN-1:0]  q_hold;
    logic [LEN-1:0]  r_hold;
    logic [IW-1:0]   id_hold;
    logic            div0_hold;

    // First pending request at or above ptr, wrapping past NREQ-1.
    always_comb begin
        found  = 1'b0;
        sel_id = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && REQ[(int'(ptr) + k) % NREQ]) begin
                found  = 1'b1;
                sel_id = IW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    assign ptr_nxt = (sel_id == IW'(NREQ - 1)) ? '0 : sel_id + 1'b1;
    assign sel_a   = REQ_A[sel_id*LEN +: LEN];
    assign sel_b   = REQ_B[sel_id*LEN +: LEN];

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (cnt == CW'(1)) begin
                    fin       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (found) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register here samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= '0;
            gnt_id    <= '0;
            ACK       <= '0;
            RSP_VALID <= '0;
            q_hold    <= '0;
            r_hold    <= '0;
            id_hold   <= '0;
            div0_hold <= 1'b0;
        end else begin
            state     <= state_nxt;
            ACK       <= '0;
            RSP_VALID <= '0;
            if (load) begin
                cnt    <= CW'(LEN);
                gnt_id <= sel_id;
                ptr    <= ptr_nxt;
                ACK    <= NREQ'(1) << sel_id;
            end else if (step) begin
                cnt <= cnt - 1'b1;
            end
            if (fin) begin
                RSP_VALID <= NREQ'(1) << gnt_id;
            end
            // The core may be reloaded at this edge, so keep the response for later cycles.
            if (state == RESP) begin
                q_hold    <= core_nq;
                r_hold    <= core_r;
                id_hold   <= gnt_id;
                div0_hold <= core_bz;
            end
        end
    end

    always_comb begin
        if (state == RESP) begin
            Q      = core_nq;
            R      = core_r;
            RSP_ID = gnt_id;
            DIV0   = core_bz;
        end else begin
            Q      = q_hold;
            R      = r_hold;
            RSP_ID = id_hold;
            DIV0   = div0_hold;
        end
    end

    assign BUSY = (state != IDLE);

    div_core #(
        .LEN (LEN)
    ) u_core (
        .CLK    (CLK),
        .load   (load),
        .step   (step),
        .a      (sel_a),
        .b      (sel_b),
        .nq     (core_nq),
        .r      (core_r),
        .b_zero (core_bz)
    );

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: transaction-level reference model with
// per-cycle expectations, directed scenarios and randomized traffic.
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    localparam int LEN  = 16;
    localparam int NREQ = 4;
    localparam int MAXC = 4096;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [NREQ-1:0]      REQ = '0;
    logic [NREQ*LEN-1:0]  REQ_A;
    logic [NREQ*LEN-1:0]  REQ_B;
    logic [NREQ-1:0]      ACK;
    logic [NREQ-1:0]      RSP_VALID;
    logic [IDW-1:0]       RSP_ID;
    logic [LEN-1:0]       Q;
    logic [LEN-1:0]       R;
    logic                 DIV0;
    logic                 BUSY;

    always #5 CLK = ~CLK;

    div_arbiter #(.LEN(LEN), .NREQ(NREQ)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .REQ       (REQ),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .ACK       (ACK),
        .RSP_VALID (RSP_VALID),
        .RSP_ID    (RSP_ID),
        .Q         (Q),
        .R         (R),
        .DIV0      (DIV0),
        .BUSY      (BUSY)
    );

    // Requester-side operand registers and protocol state (0 idle, 1 requesting, 2 waiting).
    logic [LEN-1:0] a_v [NREQ];
    logic [LEN-1:0] b_v [NREQ];
    int             st  [NREQ];
    bit             auto_rr [NREQ];

    always_comb begin
        REQ_A = '0;
        REQ_B = '0;
        for (int i = 0; i < NREQ; i++) begin
            REQ_A[i*LEN +: LEN] = a_v[i];
            REQ_B[i*LEN +: LEN] = b_v[i];
        end
    end

    // Reference model: expectations indexed by cycle number.
    logic [NREQ-1:0] exp_ack  [MAXC];
    logic [NREQ-1:0] exp_rsp  [MAXC];
    bit              exp_busy [MAXC];
    logic [LEN-1:0]  exp_q    [MAXC];
    logic [LEN-1:0]  exp_r    [MAXC];
    int              exp_id   [MAXC];
    bit              exp_dz   [MAXC];

    int             cyc        = 0;
    int             rr_ptr     = 0;
    int             free_at    = 0;
    int             m_reset_at = -1;
    logic [LEN-1:0] m_q        = '0;
    logic [LEN-1:0] m_r        = '0;
    int             m_id       = 0;
    bit             m_dz       = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    int dut_grants [$];
    int dut_rsp_cycles [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    endtask

    task automatic issue(input int i, input logic [LEN-1:0] a, input logic [LEN-1:0] b);
        a_v[i] = a;
        b_v[i] = b;
        REQ[i] = 1'b1;
        st[i]  = 1;
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < NREQ; i++) if (st[i] != 0) p = 1'b1;
        return p;
    endfunction

    // Evaluate the model for the coming edge, clock once, then compare every output.
    task automatic tick();
        int g;
        int t;
        if (cyc + LEN + 2 >= MAXC) begin
            $display("FAIL cycle_budget cycle %0d: got exhausted expected below %0d", cyc, MAXC);
            $fatal(1);
        end
        if (RST) begin
            for (int x = cyc + 1; x < MAXC; x++) begin
                exp_ack[x]  = '0;
                exp_rsp[x]  = '0;
                exp_busy[x] = 1'b0;
            end
            rr_ptr     = 0;
            free_at    = cyc + 1;
            m_reset_at = cyc + 1;
            REQ        = '0;
            for (int i = 0; i < NREQ; i++) st[i] = 0;
        end else if (cyc >= free_at && REQ != '0) begin
            g = -1;
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && REQ[(rr_ptr + k) % NREQ]) g = (rr_ptr + k) % NREQ;
            t = cyc + LEN + 1;
            exp_ack[cyc+1][g] = 1'b1;
            exp_rsp[t][g]     = 1'b1;
            exp_id[t]         = g;
            if (b_v[g] == '0) begin
                exp_q[t]  = '1;
                exp_r[t]  = a_v[g];
                exp_dz[t] = 1'b1;
            end else begin
                exp_q[t]  = a_v[g] / b_v[g];
                exp_r[t]  = a_v[g] % b_v[g];
                exp_dz[t] = 1'b0;
            end
            for (int x = cyc + 1; x <= t; x++) exp_busy[x] = 1'b1;
            free_at = t;
            rr_ptr  = (g + 1) % NREQ;
        end

        @(posedge CLK);
        #1;
        cyc++;

        if (cyc == m_reset_at) begin
            m_q  = '0;
            m_r  = '0;
            m_id = 0;
            m_dz = 1'b0;
        end else if (exp_rsp[cyc] != '0) begin
            m_q  = exp_q[cyc];
            m_r  = exp_r[cyc];
            m_id = exp_id[cyc];
            m_dz = exp_dz[cyc];
        end

        check("ack",       32'(ACK),       32'(exp_ack[cyc]));
        check("rsp_valid", 32'(RSP_VALID), 32'(exp_rsp[cyc]));
        check("busy",      32'(BUSY),      32'(exp_busy[cyc]));
        check("q",         32'(Q),         32'(m_q));
        check("r",         32'(R),         32'(m_r));
        check("rsp_id",    32'(RSP_ID),    32'(m_id));
        check("div0",      32'(DIV0),      32'(m_dz));

        for (int i = 0; i < NREQ; i++) if (ACK[i]) dut_grants.push_back(i);
        if (RSP_VALID != '0) dut_rsp_cycles.push_back(cyc);

        for (int i = 0; i < NREQ; i++) begin
            if (exp_ack[cyc][i]) begin
                REQ[i] = 1'b0;
                st[i]  = 2;
            end
            if (exp_rsp[cyc][i]) begin
                st[i] = 0;
                if (auto_rr[i]) issue(i, 16'($urandom), 16'($urandom));
            end
        end
    endtask

    task automatic do_reset();
        REQ = '0;
        for (int i = 0; i < NREQ; i++) begin
            st[i]      = 0;
            auto_rr[i] = 1'b0;
        end
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 8 * (LEN + 1) && pending(); k++) tick();
        check("drain_pending", 32'(pending()), 32'd0);
        tick();
        tick();
    endtask

    task automatic run_one(input int i, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                           input logic [LEN-1:0] eq, input logic [LEN-1:0] er, input bit ez);
        issue(i, a, b);
        tick();
        check("pt_ack", 32'(ACK), 32'(1 << i));
        repeat (LEN) tick();
        check("pt_rsp_valid", 32'(RSP_VALID), 32'(1 << i));
        check("pt_q",         32'(Q),         32'(eq));
        check("pt_r",         32'(R),         32'(er));
        check("pt_div0",      32'(DIV0),      32'(ez));
        check("pt_rsp_id",    32'(RSP_ID),    32'(i));
        tick();
        check("pt_idle_busy", 32'(BUSY), 32'd0);
        check("pt_q_hold",    32'(Q),    32'(eq));
        tick();
    endtask

    initial begin
        int  t0;
        bit  drop;
        logic [LEN-1:0] a;
        logic [LEN-1:0] b;

        for (int x = 0; x < MAXC; x++) begin
            exp_ack[x]  = '0;
            exp_rsp[x]  = '0;
            exp_busy[x] = 1'b0;
            exp_q[x]    = '0;
            exp_r[x]    = '0;
            exp_id[x]   = 0;
            exp_dz[x]   = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            a_v[i]     = '0;
            b_v[i]     = '0;
            st[i]      = 0;
            auto_rr[i] = 1'b0;
        end

        do_reset();
        tick();
        check("rst_ack",  32'(ACK),  32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_q",    32'(Q),    32'd0);

        // Directed single-requester divisions.
        run_one(1, 16'd100,  16'd7,    16'd14,   16'd2,    1'b0);
        run_one(2, 16'h1234, 16'h0,    16'hFFFF, 16'h1234, 1'b1);
        run_one(0, 16'd5,    16'd9,    16'd0,    16'd5,    1'b0);
        run_one(3, 16'hFFFF, 16'd1,    16'hFFFF, 16'h0,    1'b0);
        run_one(1, 16'hFFFF, 16'hFFFF, 16'd1,    16'h0,    1'b0);

        // All four requesters at once after reset.
        do_reset();
        for (int i = 0; i < NREQ; i++) issue(i, 16'($urandom), 16'($urandom_range(1, 300)));
        dut_grants.delete();
        dut_rsp_cycles.delete();
        t0   = cyc;
        drop = 1'b0;
        for (int k = 1; k <= 4 * (LEN + 1); k++) begin
            tick();
            if (!BUSY) drop = 1'b1;
        end
        check("all4_busy_gap", 32'(drop), 32'd0);
        check("all4_grants",   32'(dut_grants.size()), 32'd4);
        check("all4_rsps",     32'(dut_rsp_cycles.size()), 32'd4);
        for (int j = 0; j < dut_grants.size() && j < 4; j++)
            check("all4_order", 32'(dut_grants[j]), 32'(j));
        for (int j = 0; j < dut_rsp_cycles.size() && j < 4; j++)
            check("all4_rsp_cycle", 32'(dut_rsp_cycles[j] - t0), 32'((j + 1) * (LEN + 1)));
        drain();

        // Fairness: requester 0 re-requests at every response while 2 keeps requesting.
        do_reset();
        auto_rr[0] = 1'b1;
        auto_rr[2] = 1'b1;
        issue(0, 16'($urandom), 16'($urandom));
        issue(2, 16'($urandom), 16'($urandom));
        dut_grants.delete();
        repeat (4 * (LEN + 1) + 1) tick();
        auto_rr[0] = 1'b0;
        auto_rr[2] = 1'b0;
        check("fair_grants", 32'(dut_grants.size() >= 4), 32'd1);
        for (int j = 0; j < dut_grants.size() && j < 4; j++)
            check("fair_order", 32'(dut_grants[j]), 32'((j % 2) * 2));
        drain();

        // Reset in the middle of a division for requester 3.
        issue(3, 16'd5000, 16'd3);
        t0 = cyc;
        repeat (8) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("abort_busy",      32'(BUSY),      32'd0);
        check("abort_q",         32'(Q),         32'd0);
        check("abort_r",         32'(R),         32'd0);
        check("abort_rsp_valid", 32'(RSP_VALID), 32'd0);
        dut_rsp_cycles.delete();
        repeat (LEN + 2) tick();
        check("abort_no_rsp", 32'(dut_rsp_cycles.size()), 32'd0);
        dut_grants.delete();
        issue(3, 16'd5000, 16'd3);
        issue(1, 16'd77,   16'd5);
        repeat (2 * (LEN + 1) + 1) tick();
        check("abort_regrant", 32'(dut_grants.size()), 32'd2);
        if (dut_grants.size() >= 2) begin
            check("abort_first",  32'(dut_grants[0]), 32'd1);
            check("abort_second", 32'(dut_grants[1]), 32'd3);
        end
        drain();

        // Randomized traffic with occasional zero and extreme denominators.
        for (int n = 0; n < 900; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (st[i] == 0 && $urandom_range(0, 3) == 0) begin
                    a = 16'($urandom);
                    case ($urandom_range(0, 9))
                        0:       b = 16'h0;
                        1:       b = 16'h1;
                        2:       b = 16'hFFFF;
                        3:       b = a;
                        4:       b = 16'($urandom_range(1, 15));
                        default: b = 16'($urandom);
                    endcase
                    if ($urandom_range(0, 7) == 0) a = 16'($urandom_range(0, 20));
                    issue(i, a, b);
                end
            end
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Round-robin arbiter and sequencer that shares one radix-2 restoring sequential divider among NREQ requesters. Each requester presents a numerator/denominator pair and a request. The block grants one request at a time, runs the divider for LEN cycles and returns quotient and remainder on a shared, ID-tagged response bus. It sits between the multiple compute blocks needing division and a single divider instance, trading throughput for area.

## Interface
- LEN, 16, operand/result width
- NREQ, 4, number of requesters (2..16)
- CLK  in  1  clock; all state changes on rising edge
- RST  in  1  synchronous active-high reset
- REQ  in  NREQ  per-requester request level
- REQ_A  in  NREQ*LEN  numerators, requester i at bits [i*LEN +: LEN]
- REQ_B  in  NREQ*LEN  denominators, same packing
- ACK  out  NREQ  one-hot, one-cycle pulse: operands of requester i captured
- RSP_VALID  out  NREQ  one-hot, one-cycle pulse: result for requester i on Q/R
- RSP_ID  out  clog2(NREQ)  index of requester owning Q/R
- Q  out  LEN  quotient
- R  out  LEN  remainder
- DIV0  out  1  last result had B==0
- BUSY  out  1  high while state != IDLE

## Operation
- States: IDLE, RUN, RESP.
- IDLE: if any REQ, select the first set bit searching upward from PTR with wrap-around.
  - At that edge: load A/B into the core, clear the core remainder, set CNT=LEN, latch GNT_ID, set ACK[GNT_ID] for the next cycle, set PTR=GNT_ID+1 mod NREQ, go to RUN.
  - No REQ: stay in IDLE.
- RUN: one divide step per edge, CNT decrements; at the edge where CNT reaches 0, go to RESP.
- Divide step (LEN-bit, unsigned):
  - nxR = {R[LEN-2:0], NQ[LEN-1]}
  - d = nxR >= D
  - NQ <= {NQ[LEN-2:0], d}
  - R <= d ? nxR-D : nxR
- RESP: Q, R, RSP_ID, DIV0 registered from the core; RSP_VALID[GNT_ID] high this cycle only.
  - Arbitration in RESP follows the IDLE rules. With a pending REQ, go straight to RUN; otherwise go to IDLE.
- Requester protocol:
  - Hold REQ and operands stable until ACK.
  - Deassert REQ in the ACK cycle or earlier.
  - A requester already granted is not re-arbitrated before its RSP.
  - REQ seen high in the RSP cycle or later is a new request.
- B==0: no special path. The algorithm yields Q=all ones, R=A, and DIV0=1.
- Q/R/RSP_ID/DIV0 hold their last response value until the next RSP.
- Reset values: state IDLE, PTR 0, ACK 0, RSP_VALID 0, RSP_ID 0, Q 0, R 0, DIV0 0, BUSY 0.
- RST mid-operation aborts the division. No ACK or RSP is issued for it, and the requester must re-request.

## Timing
- Accept edge = cycle 0. ACK high in cycle 1.
- LEN step edges at cycles 1..LEN. RSP_VALID high in cycle LEN+1 (latency LEN+1).
- Back-to-back throughput: one result per LEN+1 cycles; the next accept edge is the RESP cycle's edge.
- ACK and RSP_VALID never assert for two requesters in the same cycle. For one requester, ACK never coincides with RSP_VALID.
- BUSY is high from cycle 1 through the RESP cycle; it stays high continuously across back-to-back operations.

## Structure
- Package div_arbiter_pkg holds:
  - state enum {IDLE, RUN, RESP}
  - CNTW = clog2(LEN)+1
  - IDW = clog2(NREQ), min 1
- Sub-module div_core:
  - registers D, NQ, R and the step logic
  - inputs: load, step, a, b
  - outputs: nq, r, b_zero
  - no internal counter or FSM
- div_arbiter owns the FSM, CNT, the round-robin PTR/select, the response registers and the port unpacking.

## Test plan
LEN=16, NREQ=4.
- Single request, REQ[1] with A=100, B=7 at cycle 0 -> ACK=4'b0010 in cycle 1; RSP_VALID=4'b0010 in cycle 17; Q=14, R=2, RSP_ID=1, DIV0=0; BUSY high cycles 1..17.
- Divide by zero, A=16'h1234, B=0 -> Q=16'hFFFF, R=16'h1234, DIV0=1.
- Edge values:
  - A=5, B=9 -> Q=0, R=5
  - A=16'hFFFF, B=1 -> Q=16'hFFFF, R=0
  - A=16'hFFFF, B=16'hFFFF -> Q=1, R=0
- All four REQ high after reset, each dropped at its ACK -> grant order 0,1,2,3; RSP_VALID in cycles 17, 34, 51, 68; BUSY never drops between them.
- Fairness: REQ[0] re-raised immediately after each RSP, REQ[2] held -> grants alternate 0,2,0,2.
- RST at cycle 8 of a REQ[3] division -> no RSP_VALID; all outputs at reset values the next cycle. With REQ[3] and REQ[1] then both raised, requester 1 is granted first (PTR=0).
